// File: rtl/online_pkg.sv
// Shared constants for the radix-2 online datapath: default sizes,
// digit encoding and the select/convert controller state encoding.
package online_pkg;

  localparam int ONL_RW      = 18;
  localparam int ONL_NDIGITS = 16;
  localparam int ONL_DELTA   = 2;
  localparam int ONL_EW      = 4;

  // digit[1] = negative, digit[0] = nonzero
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_WARMUP = 2'b01;
  localparam logic [1:0] ST_RUN    = 2'b10;
  localparam logic [1:0] ST_DONE   = 2'b11;

endpackage

// File: rtl/otf_reg.sv
// On-the-fly converter: Q/QM register pair that turns a {-1,0,+1} digit
// stream into a two's-complement value without carry propagation.
module otf_reg
  import online_pkg::*;
#(
  parameter int NDIGITS = ONL_NDIGITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic [1:0]         digit,
  output logic [NDIGITS-1:0] q
);

  logic [NDIGITS-1:0] q_q, q_d;
  logic [NDIGITS-1:0] qm_q, qm_d;

  always_comb begin
    q_d  = q_q;
    qm_d = qm_q;
    if (load) begin
      q_d  = '0;
      qm_d = '1;
    end else if (en) begin
      // QM always tracks Q - 1 ulp, so a -1 digit borrows from QM instead of propagating
      case (digit)
        DIG_POS: begin
          q_d  = {q_q[NDIGITS-2:0], 1'b1};
          qm_d = {q_q[NDIGITS-2:0], 1'b0};
        end
        DIG_NEG: begin
          q_d  = {qm_q[NDIGITS-2:0], 1'b1};
          qm_d = {qm_q[NDIGITS-2:0], 1'b0};
        end
        default: begin
          q_d  = {q_q[NDIGITS-2:0], 1'b0};
          qm_d = {qm_q[NDIGITS-2:0], 1'b1};
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q  <= '0;
      qm_q <= '1;
    end else begin
      q_q  <= q_d;
      qm_q <= qm_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/online_select_otf.sv
// Digit selection, residual shift/correct and online-delay sequencing
// for the radix-2 online datapath; result conversion lives in otf_reg.
//   state  | meaning
//   IDLE   | waiting for start
//   WARMUP | online delay, accepted steps produce discarded digits
//   RUN    | accepted steps produce result digits
//   DONE   | publish result and pulse done for one cycle
module online_select_otf
  import online_pkg::*;
#(
  parameter int RW      = ONL_RW,
  parameter int NDIGITS = ONL_NDIGITS,
  parameter int DELTA   = ONL_DELTA,
  parameter int EW      = ONL_EW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [RW-1:0]      ws_in,
  input  logic [RW-1:0]      wc_in,
  output logic [RW-1:0]      ws_fb,
  output logic [RW-1:0]      wc_fb,
  output logic [1:0]         digit,
  output logic               digit_valid,
  output logic [NDIGITS-1:0] result,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(NDIGITS + DELTA + 1);
  localparam logic signed [EW:0] V_POS = (EW+1)'(2);
  localparam logic signed [EW:0] V_NEG = (EW+1)'(-3);
  localparam logic [RW-1:0] QUARTER = {2'b01, {(RW-2){1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]      ws_fb_q, ws_fb_d;
  logic [RW-1:0]      wc_fb_q, wc_fb_d;
  logic [1:0]         digit_q, digit_d;
  logic               digit_valid_q, digit_valid_d;
  logic [NDIGITS-1:0] result_q, result_d;
  logic               done_q, done_d;

  logic signed [EW:0] est_v;
  logic [1:0]         sel_dig;
  logic [RW-1:0]      ws_adj;
  logic [RW-1:0]      ws_next;
  logic [RW-1:0]      wc_next;
  logic               otf_load;
  logic               otf_en;
  logic [NDIGITS-1:0] q_val;

  // One extra estimate bit keeps the sum of two EW-bit values exact
  always_comb begin
    est_v = $signed({ws_in[RW-1], ws_in[RW-1 -: EW]})
          + $signed({wc_in[RW-1], wc_in[RW-1 -: EW]});
    sel_dig = DIG_ZERO;
    ws_adj  = ws_in;
    if (est_v >= V_POS) begin
      sel_dig = DIG_POS;
      ws_adj  = ws_in - QUARTER;
    end else if (est_v <= V_NEG) begin
      sel_dig = DIG_NEG;
      ws_adj  = ws_in + QUARTER;
    end
    ws_next = ws_adj << 1;
    wc_next = wc_in << 1;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ws_fb_d       = ws_fb_q;
    wc_fb_d       = wc_fb_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    result_d      = result_q;
    done_d        = 1'b0;
    otf_load      = 1'b0;
    otf_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          otf_load = 1'b1;
          cnt_d    = '0;
          ws_fb_d  = '0;
          wc_fb_d  = '0;
          state_d  = (DELTA > 0) ? ST_WARMUP : ST_RUN;
        end
      end
      ST_WARMUP: begin
        if (in_valid) begin
          ws_fb_d = ws_next;
          wc_fb_d = wc_next;
          digit_d = sel_dig;
          if (cnt_q == CNT_W'(DELTA - 1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          ws_fb_d       = ws_next;
          wc_fb_d       = wc_next;
          digit_d       = sel_dig;
          digit_valid_d = 1'b1;
          otf_en        = 1'b1;
          if (cnt_q == CNT_W'(NDIGITS - 1)) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        done_d   = 1'b1;
        result_d = q_val;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ws_fb_q       <= '0;
      wc_fb_q       <= '0;
      digit_q       <= DIG_ZERO;
      digit_valid_q <= 1'b0;
      result_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ws_fb_q       <= ws_fb_d;
      wc_fb_q       <= wc_fb_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      result_q      <= result_d;
      done_q        <= done_d;
    end
  end

  otf_reg #(.NDIGITS(NDIGITS)) u_otf (
    .clk   (clk),
    .reset (reset),
    .load  (otf_load),
    .en    (otf_en),
    .digit (sel_dig),
    .q     (q_val)
  );

  assign ws_fb       = ws_fb_q;
  assign wc_fb       = wc_fb_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign result      = result_q;
  assign busy        = (state_q == ST_WARMUP) || (state_q == ST_RUN);
  assign done        = done_q;

endmodule

// File: tb/tb_online_select_otf.sv
// Directed bench for online_select_otf: a value-level model (digit weights
// summed as integers) is compared every cycle, plus literal expectations.
module tb_online_select_otf;

  localparam int RW      = 18;
  localparam int NDIGITS = 16;
  localparam int DELTA   = 2;
  localparam int EW      = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               in_valid;
  logic [RW-1:0]      ws_in;
  logic [RW-1:0]      wc_in;
  logic [RW-1:0]      ws_fb;
  logic [RW-1:0]      wc_fb;
  logic [1:0]         digit;
  logic               digit_valid;
  logic [NDIGITS-1:0] result;
  logic               busy;
  logic               done;

  online_select_otf #(.RW(RW), .NDIGITS(NDIGITS), .DELTA(DELTA), .EW(EW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .ws_in       (ws_in),
    .wc_in       (wc_in),
    .ws_fb       (ws_fb),
    .wc_fb       (wc_fb),
    .digit       (digit),
    .digit_valid (digit_valid),
    .result      (result),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc, done_cnt, done_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value rules: selection from the summed top-bit estimate, then shift/correct
  function automatic int sel_of(input logic [RW-1:0] ws, input logic [RW-1:0] wc);
    int v;
    v = $signed(ws[RW-1 -: EW]) + $signed(wc[RW-1 -: EW]);
    if (v >= 2) return 1;
    if (v <= -3) return -1;
    return 0;
  endfunction

  function automatic logic [RW-1:0] ws_next_of(input logic [RW-1:0] ws, input logic [RW-1:0] wc);
    return RW'((int'(ws) - sel_of(ws, wc) * (1 << (RW-2))) * 2);
  endfunction

  function automatic logic [1:0] enc(input int p);
    return (p == 1) ? 2'b01 : (p == -1) ? 2'b11 : 2'b00;
  endfunction

  logic               m_active, m_fin;
  int                 m_steps, m_acc;
  logic [RW-1:0]      e_ws, e_wc;
  logic [1:0]         e_digit;
  logic               e_dv, e_done;
  logic [NDIGITS-1:0] e_result;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0; m_fin <= 1'b0; m_steps <= 0; m_acc <= 0;
      e_ws <= '0; e_wc <= '0; e_digit <= 2'b00; e_dv <= 1'b0;
      e_done <= 1'b0; e_result <= '0;
    end else begin
      e_dv   <= 1'b0;
      e_done <= 1'b0;
      if (m_fin) begin
        e_done   <= 1'b1;
        e_result <= m_acc[NDIGITS-1:0];
        m_fin    <= 1'b0;
      end else if (!m_active) begin
        if (start) begin
          m_active <= 1'b1; m_steps <= 0; m_acc <= 0; e_ws <= '0; e_wc <= '0;
        end
      end else if (in_valid) begin
        e_ws    <= ws_next_of(ws_in, wc_in);
        e_wc    <= RW'(int'(wc_in) * 2);
        e_digit <= enc(sel_of(ws_in, wc_in));
        if (m_steps >= DELTA) begin
          e_dv  <= 1'b1;
          m_acc <= m_acc + sel_of(ws_in, wc_in) * (1 << (NDIGITS - 1 - (m_steps - DELTA)));
        end
        if (m_steps == DELTA + NDIGITS - 1) begin
          m_active <= 1'b0;
          m_fin    <= 1'b1;
        end
        m_steps <= m_steps + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("m_ws_fb", 32'(ws_fb), 32'(e_ws));
      chk("m_wc_fb", 32'(wc_fb), 32'(e_wc));
      chk("m_digit", 32'(digit), 32'(e_digit));
      chk("m_digit_valid", 32'(digit_valid), 32'(e_dv));
      chk("m_busy", 32'(busy), 32'(m_active));
      chk("m_done", 32'(done), 32'(e_done));
      chk("m_result", 32'(result), 32'(e_result));
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      done_lat = cyc;
    end
  endtask

  function automatic logic [RW-1:0] ws_of(input int pat, input int k);
    case (pat)
      0: case (k)
           0: return 18'h08000;   // v=2  -> +1
           1: return 18'h34000;   // v=-3 -> -1
           2: return 18'h38000;   // v=-2 -> 0
           3: return 18'h04000;   // v=1  -> 0
           default: return 18'h00000;
         endcase
      1: return 18'h1C000;        // with wc, v=+14
      2: return 18'h20000;        // with wc, v=-16
      default: case (k)
           0: return 18'h10000;
           1: return 18'h3C000;
           2: return 18'h20000;
           default: return 18'h00000;
         endcase
    endcase
  endfunction

  function automatic logic [RW-1:0] wc_of(input int pat, input int k);
    case (pat)
      0: return (k >= 4) ? 18'h01234 : 18'h00000;
      1: return 18'h1C000;
      2: return 18'h20000;
      default: return 18'h00000;
    endcase
  endfunction

  task automatic run_op(input int pat, input int stall_at, input logic [15:0] exp_res,
                        input int exp_lat);
    done_cnt = 0; done_lat = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    for (int i = 0; i < DELTA; i++) begin
      in_valid = 1'b1; ws_in = '0; wc_in = '0;
      tick();
    end
    for (int k = 0; k < NDIGITS; k++) begin
      if (k == stall_at) begin
        repeat (3) begin
          in_valid = 1'b0;
          tick();
          chk("stall_dv", 32'(digit_valid), 32'd0);
          chk("stall_busy", 32'(busy), 32'd1);
        end
      end
      in_valid = 1'b1; ws_in = ws_of(pat, k); wc_in = wc_of(pat, k);
      tick();
      if (pat == 3 && k == 0) begin
        chk("sel_pos_digit", 32'(digit), 32'h1);
        chk("sel_pos_dv", 32'(digit_valid), 32'h1);
        chk("sel_pos_ws", 32'(ws_fb), 32'h00000);
        chk("sel_pos_wc", 32'(wc_fb), 32'h00000);
      end
      if (pat == 3 && k == 1) begin
        chk("sel_zero_digit", 32'(digit), 32'h0);
        chk("sel_zero_ws", 32'(ws_fb), 32'h38000);
      end
      if (pat == 3 && k == 2) begin
        chk("sel_neg_digit", 32'(digit), 32'h3);
        chk("sel_neg_ws", 32'(ws_fb), 32'h20000);
      end
    end
    in_valid = 1'b0; ws_in = '0; wc_in = '0;
    for (int w = 0; w < 8 && done_cnt == 0; w++) tick();
    tick();
    tick();
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_latency", 32'(done_lat), 32'(exp_lat));
    chk("result", 32'(result), 32'(exp_res));
    chk("done_low", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; ws_in = '0; wc_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ws_fb", 32'(ws_fb), 32'd0);
    chk("rst_wc_fb", 32'(wc_fb), 32'd0);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_dv", 32'(digit_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(3, -1, 16'h6000, 19);   // +1, 0, -1, zeros: 0.5 - 0.125
    run_op(0, -1, 16'h4000, 19);   // +1, -1, zeros: 0.25
    run_op(1, -1, 16'hFFFF, 19);
    run_op(2, -1, 16'h0001, 19);
    run_op(0, 5, 16'h4000, 22);    // 3-cycle stall adds 3 to latency only

    // Abort mid-RUN, with a start pulse while busy
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < DELTA + 5; i++) begin
      in_valid = 1'b1; ws_in = 18'h10000; wc_in = '0;
      start = (i == DELTA + 2);
      tick();
    end
    start = 1'b0;
    chk("busy_ignore_start", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ws_fb", 32'(ws_fb), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_dv", 32'(digit_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_abort_idle", 32'(busy), 32'd0);
    run_op(2, -1, 16'h0001, 19);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/online_select_otf.md
Name: online_select_otf

Overview:
- Downstream stage of adder_array in the radix-2 online (digit-serial) datapath.
- Each cycle it takes the carry-save residual (ws_o/wc_o) from adder_array and selects an output digit in {-1,0,+1}.
- It returns the shifted, corrected residual as the next ws_i/wc_i, and on-the-fly converts the digit stream into a conventional two's-complement result.
- A small controller sequences the online delay (warm-up) and the NDIGITS result digits.

Parameters:
- RW, 18: residual width (carry-save ws/wc).
- NDIGITS, 16: result digits produced; also the result width.
- DELTA, 2: online delay; number of accepted steps whose digit is discarded.
- EW, 4: estimate width, taken from residual bits [RW-1:RW-EW].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin an operation; honoured only in IDLE.
- in_valid  in  1  ws_in/wc_in hold a valid residual for this step.
- ws_in  in  RW  residual sum from adder_array ws_o.
- wc_in  in  RW  residual carry from adder_array wc_o.
- ws_fb  out  RW  registered next residual sum, to adder_array ws_i.
- wc_fb  out  RW  registered next residual carry, to adder_array wc_i.
- digit  out  2  selected digit: [1]=negative, [0]=nonzero (00=0, 01=+1, 11=-1).
- digit_valid  out  1  digit is a result digit (RUN step accepted last cycle).
- result  out  NDIGITS  converted result; valid while done=1 and held until next start.
- busy  out  1  high in WARMUP and RUN.
- done  out  1  one-cycle pulse after the last digit.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ws_fb=wc_fb=0; digit=00; digit_valid=0; busy=0; done=0; result=0; Q=0; QM=all ones; counter=0.
- States: IDLE, WARMUP, RUN, DONE.
- IDLE: start=1 loads Q=0, QM=all ones, counter=0, ws_fb=wc_fb=0. Next state is WARMUP if DELTA>0, else RUN.
- WARMUP: each accepted step (in_valid=1) updates the residual and increments the counter. When the counter reaches DELTA-1 on an accepted step, the counter clears and the state goes to RUN. No digit_valid and no Q/QM update in WARMUP.
- RUN: each accepted step updates the residual and Q/QM, and asserts digit_valid the next cycle. After the NDIGITS-th accepted step the state goes to DONE.
- DONE: done=1 and result=Q for exactly one cycle, then IDLE; result holds afterwards.
- in_valid=0 in WARMUP/RUN is a stall: all registers hold, digit_valid=0 that cycle.
- start outside IDLE is ignored. Reset mid-operation aborts immediately to the reset values.
- Estimate: v = signed(ws_in[RW-1:RW-EW]) + signed(wc_in[RW-1:RW-EW]), computed as a 5-bit signed sum with no overflow.
- Selection: p=+1 if v>=2; p=-1 if v<=-3; otherwise p=0.
- Residual update:
  - ws_fb = ((ws_in - p*2^(RW-2)) << 1) truncated to RW bits.
  - wc_fb = (wc_in << 1) truncated to RW bits.
  - This is registered, so it reaches adder_array one cycle after acceptance.
- The digit register updates on every accepted step (WARMUP and RUN); digit_valid marks the RUN steps only.
- On-the-fly conversion (RUN, accepted step), all shifts within NDIGITS bits with the MSB dropped:
  - p=+1: Q={Q,1}, QM={Q,0}.
  - p=0: Q={Q,0}, QM={QM,1}.
  - p=-1: Q={QM,1}, QM={QM,0}.
- result is Q modulo 2^NDIGITS.

Decomposition:
- Shared package online_pkg holds:
  - digit encoding constants DIG_ZERO=2'b00, DIG_POS=2'b01, DIG_NEG=2'b11;
  - state encoding;
  - defaults RW/NDIGITS/DELTA/EW.
- One natural sub-module, otf_reg: Q/QM registers with a load/shift interface, driven by digit and an enable.
- Selection, the residual update and the FSM stay in online_select_otf.

Test Plan:
- Selection, positive: RUN step, ws_in=18'h10000, wc_in=0 → next cycle digit=01, digit_valid=1, ws_fb=18'h00000, wc_fb=0.
- Selection, zero: ws_in=18'h3C000, wc_in=0 (v=-1) → digit=00, ws_fb=18'h38000.
- Selection, negative: ws_in=18'h20000, wc_in=0 (v=-8) → digit=11, ws_fb=18'h20000.
- Conversion: start, 2 warm-up steps, then digits +1,-1 followed by 14 zeros (continuous in_valid) → done pulses once, 19 cycles after start is sampled (1 load + 2 warm-up + 16 digits), with result=16'h4000.
- All-extreme digits: 16 digits of +1 → result=16'hFFFF; 16 digits of -1 → result=16'h0001.
- Stall/reset: drop in_valid for 3 cycles mid-RUN → outputs frozen, digit_valid=0, final result unchanged vs no stall. Assert reset=0 mid-RUN → busy=0, ws_fb=0, result=0 immediately; start pulse while busy → ignored.
